// File: rtl/bus_arbiter_3x16.sv
// Round-robin arbiter for the 3-source, 16-bit internal bus; drives the bus mux select.
// Tenures are capped at HOLD_MAX cycles and separated by one idle (zero-bus) cycle.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | bus zero (sel 11); requests scanned from pointer p
//   ST_GRANT | source g owns the bus; cnt counts cycles of the tenure

module bus_arbiter_3x16 #(
    parameter int HOLD_MAX = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] req_in,
    output logic [2:0] grant_out,
    output logic [1:0] sel_out,
    output logic       busy_out,
    output logic       preempt_out,
    output logic [7:0] hold_cnt_out
);

    localparam logic [7:0] HOLD_MAX_C = 8'(HOLD_MAX);

    typedef enum logic {
        ST_IDLE,
        ST_GRANT
    } state_t;

    state_t     state_q, state_d;
    logic [1:0] g_q, g_d;
    logic [1:0] p_q, p_d;
    logic [7:0] cnt_q, cnt_d;
    logic       preempt_q, preempt_d;
    logic [2:0] grant_q, grant_d;
    logic [1:0] sel_q, sel_d;
    logic       busy_q, busy_d;

    logic [1:0] pick_idx;
    logic [1:0] g_next;

    // First requester scanning p, p+1, p+2 (mod 3); only used when req_in != 0.
    always_comb begin
        pick_idx = 2'd0;
        case (p_q)
            2'd1: begin
                if (req_in[1])      pick_idx = 2'd1;
                else if (req_in[2]) pick_idx = 2'd2;
                else                pick_idx = 2'd0;
            end
            2'd2: begin
                if (req_in[2])      pick_idx = 2'd2;
                else if (req_in[0]) pick_idx = 2'd0;
                else                pick_idx = 2'd1;
            end
            default: begin
                if (req_in[0])      pick_idx = 2'd0;
                else if (req_in[1]) pick_idx = 2'd1;
                else                pick_idx = 2'd2;
            end
        endcase
    end

    assign g_next = (g_q == 2'd2) ? 2'd0 : g_q + 2'd1;

    always_comb begin
        state_d   = state_q;
        g_d       = g_q;
        p_d       = p_q;
        cnt_d     = cnt_q;
        preempt_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req_in != 3'b000) begin
                    state_d = ST_GRANT;
                    g_d     = pick_idx;
                    cnt_d   = 8'd1;
                end
            end
            ST_GRANT: begin
                // Voluntary release wins over the HOLD_MAX cap, so no preempt pulse then.
                if (!req_in[g_q]) begin
                    state_d = ST_IDLE;
                    p_d     = g_next;
                    cnt_d   = 8'd0;
                end else if (cnt_q == HOLD_MAX_C) begin
                    state_d   = ST_IDLE;
                    p_d       = g_next;
                    cnt_d     = 8'd0;
                    preempt_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 8'd0;
            end
        endcase

        // Outputs are decoded from the next state so they come straight out of flops.
        if (state_d == ST_GRANT) begin
            grant_d = 3'b001 << g_d;
            sel_d   = g_d;
            busy_d  = 1'b1;
        end else begin
            grant_d = 3'b000;
            sel_d   = 2'b11;
            busy_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            g_q       <= 2'd0;
            p_q       <= 2'd0;
            cnt_q     <= 8'd0;
            preempt_q <= 1'b0;
            grant_q   <= 3'b000;
            sel_q     <= 2'b11;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            g_q       <= g_d;
            p_q       <= p_d;
            cnt_q     <= cnt_d;
            preempt_q <= preempt_d;
            grant_q   <= grant_d;
            sel_q     <= sel_d;
            busy_q    <= busy_d;
        end
    end

    assign grant_out    = grant_q;
    assign sel_out      = sel_q;
    assign busy_out     = busy_q;
    assign preempt_out  = preempt_q;
    assign hold_cnt_out = cnt_q;

endmodule

// File: tb/tb_bus_arbiter_3x16.sv
// Directed bench for bus_arbiter_3x16: three instances with HOLD_MAX 8, 4 and 2,
// each driven with hand-computed vectors.

module tb_bus_arbiter_3x16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_a, rst_b, rst_c;
    logic [2:0] req_a, req_b, req_c;

    logic [2:0] grant_a, grant_b, grant_c;
    logic [1:0] sel_a, sel_b, sel_c;
    logic       busy_a, busy_b, busy_c;
    logic       pre_a, pre_b, pre_c;
    logic [7:0] cnt_a, cnt_b, cnt_c;

    int n_tests = 0;
    int n_fail  = 0;

    bus_arbiter_3x16 #(.HOLD_MAX(8)) u_dut_a (
        .clk(clk), .rst(rst_a), .req_in(req_a),
        .grant_out(grant_a), .sel_out(sel_a), .busy_out(busy_a),
        .preempt_out(pre_a), .hold_cnt_out(cnt_a)
    );

    bus_arbiter_3x16 #(.HOLD_MAX(4)) u_dut_b (
        .clk(clk), .rst(rst_b), .req_in(req_b),
        .grant_out(grant_b), .sel_out(sel_b), .busy_out(busy_b),
        .preempt_out(pre_b), .hold_cnt_out(cnt_b)
    );

    bus_arbiter_3x16 #(.HOLD_MAX(2)) u_dut_c (
        .clk(clk), .rst(rst_c), .req_in(req_c),
        .grant_out(grant_c), .sel_out(sel_c), .busy_out(busy_c),
        .preempt_out(pre_c), .hold_cnt_out(cnt_c)
    );

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_a(input string tag, input logic [2:0] g, input logic [1:0] s,
                         input logic b, input logic p, input logic [7:0] c);
        check({tag, " grant"}, 16'(grant_a), 16'(g));
        check({tag, " sel"},   16'(sel_a),   16'(s));
        check({tag, " busy"},  16'(busy_a),  16'(b));
        check({tag, " pre"},   16'(pre_a),   16'(p));
        check({tag, " cnt"},   16'(cnt_a),   16'(c));
    endtask

    task automatic chk_b(input string tag, input logic [2:0] g, input logic [1:0] s,
                         input logic b, input logic p, input logic [7:0] c);
        check({tag, " grant"}, 16'(grant_b), 16'(g));
        check({tag, " sel"},   16'(sel_b),   16'(s));
        check({tag, " busy"},  16'(busy_b),  16'(b));
        check({tag, " pre"},   16'(pre_b),   16'(p));
        check({tag, " cnt"},   16'(cnt_b),   16'(c));
    endtask

    // Round robin at HOLD_MAX=2 with all three requesting: owners 0,0,idle,1,1,idle,2,2,idle,0
    logic [2:0] rr_grant [10] = '{3'b001, 3'b001, 3'b000, 3'b010, 3'b010,
                                  3'b000, 3'b100, 3'b100, 3'b000, 3'b001};
    logic [1:0] rr_sel   [10] = '{2'b00, 2'b00, 2'b11, 2'b01, 2'b01,
                                  2'b11, 2'b10, 2'b10, 2'b11, 2'b00};
    logic       rr_pre   [10] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0,
                                  1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [7:0] rr_cnt   [10] = '{8'd1, 8'd2, 8'd0, 8'd1, 8'd2,
                                  8'd0, 8'd1, 8'd2, 8'd0, 8'd1};

    initial begin
        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
        req_a = 3'b111; req_b = 3'b000; req_c = 3'b111;

        // Reset held two cycles with requests present
        step();
        step();
        chk_a("rst", 3'b000, 2'b11, 1'b0, 1'b0, 8'd0);
        chk_b("rst_b", 3'b000, 2'b11, 1'b0, 1'b0, 8'd0);
        check("rst_c grant", 16'(grant_c), 16'h0);
        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;

        // First cycle after reset: source 0 granted on A; C starts round robin
        req_b = 3'b100;
        step();
        chk_a("first", 3'b001, 2'b00, 1'b1, 1'b0, 8'd1);
        check("rr0 grant", 16'(grant_c), 16'(rr_grant[0]));
        check("rr0 sel",   16'(sel_c),   16'(rr_sel[0]));
        check("rr0 pre",   16'(pre_c),   16'(rr_pre[0]));
        check("rr0 cnt",   16'(cnt_c),   16'(rr_cnt[0]));
        chk_b("fr1", 3'b100, 2'b10, 1'b1, 1'b0, 8'd1);

        // A: release source 0 (p=1); B: forced release at HOLD_MAX=4
        req_a = 3'b000;
        step();
        chk_a("rel0", 3'b000, 2'b11, 1'b0, 1'b0, 8'd0);
        chk_b("fr2", 3'b100, 2'b10, 1'b1, 1'b0, 8'd2);
        check("rr1 grant", 16'(grant_c), 16'(rr_grant[1]));
        check("rr1 cnt",   16'(cnt_c),   16'(rr_cnt[1]));

        // A: single requester, voluntary release
        req_a = 3'b010;
        for (int i = 2; i < 10; i++) begin
            step();
            if (i <= 4)
                chk_a($sformatf("vol%0d", i - 1), 3'b010, 2'b01, 1'b1, 1'b0, 8'(i - 1));
            if (i == 4)
                req_a = 3'b000;
            if (i == 5)
                chk_a("volrel", 3'b000, 2'b11, 1'b0, 1'b0, 8'd0);
            if (i == 2) chk_b("fr3", 3'b100, 2'b10, 1'b1, 1'b0, 8'd3);
            if (i == 3) chk_b("fr4", 3'b100, 2'b10, 1'b1, 1'b0, 8'd4);
            if (i == 4) chk_b("frpre", 3'b000, 2'b11, 1'b0, 1'b1, 8'd0);
            if (i == 5) chk_b("frregrant", 3'b100, 2'b10, 1'b1, 1'b0, 8'd1);
            if (i == 8) begin
                chk_b("vmax4", 3'b100, 2'b10, 1'b1, 1'b0, 8'd4);
                req_b = 3'b000;
            end
            if (i == 9)
                chk_b("vmaxrel", 3'b000, 2'b11, 1'b0, 1'b0, 8'd0);
            check($sformatf("rr%0d grant", i), 16'(grant_c), 16'(rr_grant[i]));
            check($sformatf("rr%0d sel", i),   16'(sel_c),   16'(rr_sel[i]));
            check($sformatf("rr%0d pre", i),   16'(pre_c),   16'(rr_pre[i]));
            check($sformatf("rr%0d cnt", i),   16'(cnt_c),   16'(rr_cnt[i]));
        end

        // A is idle with p=2; grant source 0 alone, then release -> p=1
        req_a = 3'b001;
        step();
        chk_a("p2pick0", 3'b001, 2'b00, 1'b1, 1'b0, 8'd1);
        req_a = 3'b000;
        step();
        chk_a("p2rel", 3'b000, 2'b11, 1'b0, 1'b0, 8'd0);

        // Pointer skip: p=1 with 101 requesting picks source 2
        req_a = 3'b101;
        step();
        chk_a("skip", 3'b100, 2'b10, 1'b1, 1'b0, 8'd1);
        req_a = 3'b000;
        step();
        chk_a("skiprel", 3'b000, 2'b11, 1'b0, 1'b0, 8'd0);

        // Reset mid-tenure: source 1 at count 3, then rst pulse
        req_a = 3'b010;
        step();
        step();
        step();
        chk_a("mid3", 3'b010, 2'b01, 1'b1, 1'b0, 8'd3);
        rst_a = 1'b1;
        req_a = 3'b011;
        step();
        chk_a("midrst", 3'b000, 2'b11, 1'b0, 1'b0, 8'd0);
        rst_a = 1'b0;
        step();
        chk_a("postrst", 3'b001, 2'b00, 1'b1, 1'b0, 8'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
